// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MAT,
    LOAD_VEC,
    MAC,
    OUT
  } state_t;

  // Bits needed to index n entries (never less than one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_mac.sv
// Registered signed multiply-accumulate with synchronous clear and sticky overflow.
// Define MVM_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mvm_mac #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [IN_W-1:0]  a_i,
  input  logic signed [IN_W-1:0]  b_i,
  output logic signed [OUT_W-1:0] acc_o,
  output logic                    ovf_o
);

`ifdef MVM_SATURATE_EN
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

  logic signed [2*IN_W-1:0] prod_q, prod_d;
  logic                     vld_q;
  logic signed [OUT_W-1:0]  acc_q, acc_d, prod_ext, sum;
  logic                     ovf_q, ovf_d, add_ovf;

  // Product is registered first; the accumulate stage follows one cycle later.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    prod_d   = a_i * b_i;
    prod_ext = OUT_W'(prod_q);
    sum      = acc_q + prod_ext;
    add_ovf  = (acc_q[OUT_W-1] == prod_ext[OUT_W-1]) && (sum[OUT_W-1] != acc_q[OUT_W-1]);
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (vld_q) begin
      ovf_d = ovf_q | add_ovf;
`ifdef MVM_SATURATE_EN
      if (add_ovf) acc_d = prod_ext[OUT_W-1] ? SAT_MIN : SAT_MAX;
      else         acc_d = sum;
`else
      acc_d = sum;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (en_i) prod_q <= prod_d;
      vld_q <= en_i;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mvm_param.sv
// Streaming signed y = A*x (M x M) with stored-matrix reuse and valid/ready streams.
// Define MVM_SATURATE_EN to saturate results on overflow (default: two's-complement wrap).
module mvm_param
  import mvm_pkg::*;
#(
  parameter int M     = 3,
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [IN_W-1:0]  data_in,
  input  logic                    new_matrix,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [OUT_W-1:0] data_out,
  output logic                    overflow
);

  localparam int CNT_W  = cnt_w(M * M);
  localparam int XIDX_W = cnt_w(M);
  localparam int ROW_W  = cnt_w(M);
  localparam logic [CNT_W-1:0] LAST_MAT = CNT_W'(M * M - 1);
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] MAC_END  = CNT_W'(M);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, ptr_q, ptr_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               loaded_q, loaded_d;
  logic               s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic               accept, load_a, a_we, x_we, mac_en, mac_clr;
  logic signed [IN_W-1:0] mac_a, mac_b;

  logic signed [IN_W-1:0] a_mem [M*M];
  logic signed [IN_W-1:0] x_mem [M];

  assign accept = s_valid && s_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      row_q     <= '0;
      loaded_q  <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      row_q     <= row_d;
      loaded_q  <= loaded_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    row_d    = row_q;
    loaded_d = loaded_q;
    unique case (state_q)
      IDLE: if (accept) begin
        cnt_d   = CNT_W'(1);
        state_d = (new_matrix || !loaded_q) ? LOAD_MAT : LOAD_VEC;
      end
      LOAD_MAT: if (accept) begin
        if (cnt_q == LAST_MAT) begin
          cnt_d    = '0;
          loaded_d = 1'b1;
          state_d  = LOAD_VEC;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      LOAD_VEC: if (accept) begin
        if (cnt_q == LAST_VEC) begin
          cnt_d   = '0;
          ptr_d   = '0;
          row_d   = '0;
          state_d = MAC;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      // One extra MAC cycle lets the last registered product reach the accumulator.
      MAC: begin
        if (cnt_q == MAC_END) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          ptr_d = ptr_q + CNT_W'(1);
        end
      end
      OUT: if (m_ready) begin
        if (row_q == ROW_LAST) state_d = IDLE;
        else begin
          row_d   = row_q + ROW_W'(1);
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready_d = (state_d == IDLE) || (state_d == LOAD_MAT) || (state_d == LOAD_VEC);
    m_valid_d = (state_d == OUT);
    load_a    = (state_q == LOAD_MAT) || ((state_q == IDLE) && (new_matrix || !loaded_q));
    a_we      = accept && load_a;
    x_we      = accept && !load_a;
    mac_en    = (state_q == MAC) && (cnt_q != MAC_END);
    mac_clr   = (state_d == MAC) && (state_q != MAC);
    mac_a     = a_mem[ptr_q];
    mac_b     = x_mem[cnt_q[XIDX_W-1:0]];
  end

  // NOTE: operand storage has no reset; its contents are only read after being written.
  always_ff @(posedge clk) begin
    if (a_we) a_mem[cnt_q] <= data_in;
    if (x_we) x_mem[cnt_q[XIDX_W-1:0]] <= data_in;
  end

  mvm_mac #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (mac_a),
    .b_i   (mac_b),
    .acc_o (data_out),
    .ovf_o (overflow)
  );

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_mvm_param.sv
// Self-checking bench for mvm_param: behavioural model + scoreboard and directed vectors.
module tb_mvm_param;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int M3    = 3;
  localparam int M4    = 4;
  localparam int Y_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int Y_MIN = -(2 ** (OUT_W - 1));
`ifdef MVM_SATURATE_EN
  localparam int T3_Y = 32767;
`else
  localparam int T3_Y = -17149;
`endif

  typedef struct {
    int y;
    bit ovf;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  logic s_valid, s_ready, new_matrix, m_valid, m_ready, overflow;
  logic signed [IN_W-1:0]  data_in;
  logic signed [OUT_W-1:0] data_out;
  logic s4_valid, s4_ready, s4_nm, m4_valid, m4_ready, ovf4;
  logic signed [IN_W-1:0]  s4_data;
  logic signed [OUT_W-1:0] y4;

  mvm_param #(.M(M3), .IN_W(IN_W), .OUT_W(OUT_W)) dut3 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
    .new_matrix(new_matrix), .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
    .overflow(overflow)
  );

  mvm_param #(.M(M4), .IN_W(IN_W), .OUT_W(OUT_W)) dut4 (
    .clk(clk), .reset(reset), .s_valid(s4_valid), .s_ready(s4_ready), .data_in(s4_data),
    .new_matrix(s4_nm), .m_valid(m4_valid), .m_ready(m4_ready), .data_out(y4),
    .overflow(ovf4)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   model_a[256];
  bit   model_loaded = 1'b0;
  bit   rand_mode = 1'b0;
  int   words[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Plain integer arithmetic: accumulate each row, then wrap or clamp on range violation.
  function automatic void model_calc(input int m, input int a[256], input int x[16],
                                     output int ry[16], output bit ro[16]);
    for (int r = 0; r < 16; r++) begin
      ry[r] = 0;
      ro[r] = 1'b0;
    end
    for (int r = 0; r < m; r++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < m; k++) begin
        acc = acc + a[r * m + k] * x[k];
        if (acc > Y_MAX || acc < Y_MIN) begin
          ro[r] = 1'b1;
`ifdef MVM_SATURATE_EN
          acc = (acc > Y_MAX) ? Y_MAX : Y_MIN;
`else
          acc = ((acc - Y_MIN) & (2 ** OUT_W - 1)) + Y_MIN;
`endif
        end
      end
      ry[r] = acc;
    end
  endfunction

  task automatic send_job(input bit nm, input int w[$]);
    int i = 0;
    int g = 0;
    while (i < w.size() && g < 2000) begin
      @(negedge clk);
      g++;
      if (rand_mode && $urandom_range(0, 2) == 0) begin
        s_valid    = 1'b0;
        data_in    = 'x;
        new_matrix = 1'bx;
      end else begin
        s_valid    = 1'b1;
        data_in    = IN_W'(w[i]);
        new_matrix = (i == 0) ? nm : !nm;
        if (s_ready) i++;
      end
    end
    check("send words", i, w.size());
    @(negedge clk);
    s_valid = 1'b0;
    data_in = 'x;
  endtask

  task automatic run_job(input bit nm, input int w[$]);
    int   x[16];
    int   ry[16];
    bit   ro[16];
    int   base;
    res_t e;
    x = '{default: 0};
    base = 0;
    if (nm || !model_loaded) begin
      for (int i = 0; i < M3 * M3; i++) model_a[i] = w[i];
      base = M3 * M3;
      model_loaded = 1'b1;
    end
    for (int k = 0; k < M3; k++) x[k] = w[base + k];
    model_calc(M3, model_a, x, ry, ro);
    for (int r = 0; r < M3; r++) begin
      e.y   = ry[r];
      e.ovf = ro[r];
      exp_q.push_back(e);
    end
    send_job(nm, w);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(negedge clk);
      g++;
    end
    check("drain outputs", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_got(input string name, input int ys[3], input bit ov);
    check({name, " count"}, got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) begin
        check({name, " y"}, got_q[i].y, ys[i]);
        check({name, " ovf"}, int'(got_q[i].ovf), int'(ov));
      end
    end
    got_q.delete();
  endtask

  // Output-side process: drives m_ready, scoreboards every handshake, checks hold and exclusivity.
  initial begin
    res_t e;
    res_t g;
    bit   prev_stall;
    int   prev_y;
    int   prev_ovf;
    prev_stall = 1'b0;
    prev_y     = 0;
    prev_ovf   = 0;
    forever begin
      @(negedge clk);
      m_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (reset === 1'b1 && m_valid === 1'b1) begin
        check("s_ready with m_valid", int'(s_ready), 0);
        if (prev_stall) begin
          check("hold data_out", int'(data_out), prev_y);
          check("hold overflow", int'(overflow), prev_ovf);
        end
        if (m_ready) begin
          prev_stall = 1'b0;
          if (exp_q.size() == 0) check("unexpected output", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("model y", int'(data_out), e.y);
            check("model ovf", int'(overflow), int'(e.ovf));
            g.y   = int'(data_out);
            g.ovf = overflow;
            got_q.push_back(g);
          end
        end else begin
          prev_stall = 1'b1;
          prev_y     = int'(data_out);
          prev_ovf   = int'(overflow);
        end
      end else prev_stall = 1'b0;
    end
  end

  int w4[20];
  int a4[256];
  int x4[16];
  int ry4[16];
  bit ro4[16];
  int ys4[4] = '{-128, 127, 0, -1};

  initial begin
    int k;
    int i;
    int g;
    reset = 1'b0;
    s_valid = 1'b0; data_in = '0; new_matrix = 1'b0; m_ready = 1'b0;
    s4_valid = 1'b0; s4_data = '0; s4_nm = 1'b0; m4_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset s_ready", int'(s_ready), 0);
    check("reset m_valid", int'(m_valid), 0);
    check("reset data_out", int'(data_out), 0);
    check("reset overflow", int'(overflow), 0);
    reset = 1'b1;
    @(negedge clk);
    check("s_ready after reset", int'(s_ready), 1);

    // Case 1: full load, A=1..9, x=1,2,3; also measure first-result latency.
    words = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3};
    run_job(1'b1, words);
    k = 1;
    while (m_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("latency negedges", k, M3 + 2);
    drain();
    check_got("case1", '{14, 32, 50}, 1'b0);

    // Case 2: reuse stored A, vector only.
    words = '{3, 2, 1};
    run_job(1'b0, words);
    drain();
    check_got("reuse", '{10, 28, 46}, 1'b0);

    // Case 3: overflow on every row.
    words = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
    run_job(1'b1, words);
    drain();
    check_got("overflow", '{T3_Y, T3_Y, T3_Y}, 1'b1);

    // Case 4: random valid/ready with X on idle data.
    rand_mode = 1'b1;
    words = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 2, 3};
    run_job(1'b1, words);
    drain();
    check_got("random", '{14, 32, 50}, 1'b0);
    rand_mode = 1'b0;

    // Case 5: abort mid-matrix-load, then a new_matrix=0 job must still do a full load.
    words = '{1, 2, 3, 4, 5};
    send_job(1'b1, words);
    reset = 1'b0;
    model_loaded = 1'b0;
    exp_q.delete();
    got_q.delete();
    @(negedge clk);
    check("mid reset s_ready", int'(s_ready), 0);
    check("mid reset m_valid", int'(m_valid), 0);
    reset = 1'b1;
    @(negedge clk);
    words = '{-1, 2, -3, 4, -5, 6, -7, 8, -9, 2, -1, 3};
    run_job(1'b0, words);
    drain();
    check_got("after abort", '{-13, 31, -49}, 1'b0);

    // Case 6: M=4 identity on extreme vector.
    for (int j = 0; j < 16; j++) w4[j] = (j % 5 == 0) ? 1 : 0;
    w4[16] = -128; w4[17] = 127; w4[18] = 0; w4[19] = -1;
    a4 = '{default: 0};
    x4 = '{default: 0};
    for (int j = 0; j < 16; j++) a4[j] = w4[j];
    for (int j = 0; j < 4; j++) x4[j] = w4[16 + j];
    model_calc(M4, a4, x4, ry4, ro4);
    i = 0;
    g = 0;
    while (i < 20 && g < 500) begin
      @(negedge clk);
      g++;
      s4_valid = 1'b1;
      s4_data  = IN_W'(w4[i]);
      s4_nm    = 1'b1;
      if (s4_ready) i++;
    end
    check("m4 words", i, 20);
    @(negedge clk);
    s4_valid = 1'b0;
    for (int r = 0; r < M4; r++) begin
      g = 0;
      while (m4_valid !== 1'b1 && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("m4 valid", int'(m4_valid), 1);
      check("m4 y", int'(y4), ys4[r]);
      check("m4 model y", int'(y4), ry4[r]);
      check("m4 ovf", int'(ovf4), int'(ro4[r]));
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
